fma_acc_sequencer: RTL and testbench
====================================

Name: fma_acc_sequencer

Overview:
- Control FSM that sequences one fused dot-product session on the fixed-point FMA accumulator datapath: fir-to-fixed conversion, accumulator, and fixed-to-fir conversion.
- Accepts a command (term count), pulses the accumulator init-load, then streams operand pairs through the multiplier.
- Tracks in-flight products over the multiplier latency, drains them, and presents a held result-valid handshake.
- Sits between the PPU front-end and the accumulator datapath; it is control-only, and data flows alongside it.

Parameters:
- MUL_LATENCY, 2, cycles from operand acceptance to product at accumulator input (>=1).
- MAX_TERMS, 256, largest legal term count per session.
- CNT_W, $clog2(MAX_TERMS+1), width of the term counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  session request.
- cmd_ready_o  out  1  sequencer can accept a command (IDLE only).
- cmd_len_i  in  CNT_W  number of product terms L.
- opnd_valid_i  in  1  operand pair available.
- opnd_ready_o  out  1  operand pair accepted this cycle when valid is also high.
- in_last_o  out  1  accepted operand is the L-th of the session.
- acc_load_o  out  1  accumulator loads its init addend (fir2 fixed).
- acc_add_o  out  1  accumulator adds the product at its input this cycle.
- abort_i  in  1  synchronous session cancel.
- result_valid_o  out  1  accumulator output (fixed_o / fir_fma) is final.
- result_ready_i  in  1  consumer takes the result.
- busy_o  out  1  state != IDLE.
- issued_o  out  CNT_W  operands accepted in the current session.

Behaviour:
- Reset values (rst_i high, any state):
  - state=IDLE, all counters and token pipe cleared.
  - cmd_ready_o=1 (combinational from IDLE); every other output 0.
- States: IDLE, LOAD, ISSUE, DRAIN, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch L (saturate to MAX_TERMS), go to LOAD.
- LOAD (1 cycle):
  - acc_load_o=1.
  - Next state is DONE if L==0, else ISSUE.
- ISSUE:
  - opnd_ready_o=1 while issued<L.
  - Each handshake increments issued and pushes a token into a MUL_LATENCY-deep shift register.
  - in_last_o=1 on the handshake where issued==L-1.
  - After the last handshake, go to DRAIN.
- Token pipe:
  - acc_add_o equals the pipe output; the pipe shifts every cycle in ISSUE and DRAIN.
  - Tokens are never dropped except by abort or reset.
- DRAIN:
  - opnd_ready_o=0.
  - Go to DONE in the cycle after the pipe becomes empty and acc_add_o=0, so the last add has registered.
- DONE:
  - result_valid_o=1, held stable until result_ready_i.
  - On handshake, go to IDLE; the next command may be accepted in the following cycle.
- Latency, with continuous operands and cmd accepted at cycle 0:
  - LOAD at cycle 1; operands accepted at cycles 2..L+1.
  - Last acc_add_o at cycle L+1+MUL_LATENCY.
  - result_valid_o rises at cycle L+2+MUL_LATENCY.
  - L=0: result_valid_o rises at cycle 2.
- Back-pressure: opnd_valid_i gaps stall issue only; tokens already in the pipe still arrive on schedule.
- abort_i:
  - In LOAD, ISSUE or DRAIN: next cycle IDLE, pipe flushed, no result_valid_o.
  - In DONE: ignored.
  - In IDLE: no effect.
  - abort_i wins over a simultaneous operand handshake; that operand is not counted.
- Simultaneous cmd_valid_i and result handshake: the command is not accepted that cycle, because cmd_ready_o is low outside IDLE.
- Asynchronous reset mid-session: immediate IDLE, pipe flushed, outputs low.

Decomposition:
- ppu_pkg gains seq_state_e (IDLE/LOAD/ISSUE/DRAIN/DONE) and a default constant FMA_MUL_LATENCY.
- One sub-module, fma_token_pipe: a parameterised 1-bit delay line with flush input, used for the in-flight product tokens.

Test Plan:
- L=3, MUL_LATENCY=2, operands valid continuously -> acc_load_o at cycle 1; opnd handshakes at cycles 2,3,4; in_last_o at cycle 4; acc_add_o at cycles 4,5,6; result_valid_o at cycle 7.
- L=0 -> acc_load_o at cycle 1, result_valid_o at cycle 2, no acc_add_o or opnd_ready_o ever.
- L=4, opnd_valid_i low at cycles 3-5 -> exactly 4 acc_add_o pulses spaced 2 cycles after each handshake; issued_o ends at 4.
- result_ready_i held low 5 cycles in DONE -> result_valid_o stable for 5 cycles; cmd_valid_i ignored (cmd_ready_o=0) until 1 cycle after handshake.
- abort_i at the 2nd operand of L=5 -> IDLE next cycle, acc_add_o stops within 0 cycles (pipe flushed), no result_valid_o; a new L=1 session then completes normally.
- rst_i asserted asynchronously mid-DRAIN -> all outputs 0 and busy_o=0 before the next clock edge; cmd_ready_o=1 after release.

Source files
------------

// File: rtl/fma_acc_sequencer_pkg.sv
// Shared types and defaults for the FMA accumulator session sequencer.
package fma_acc_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StDrain,
        StDone
    } seq_state_e;

    localparam int unsigned FMA_MUL_LATENCY = 2;
    localparam int unsigned FMA_MAX_TERMS   = 256;

endpackage

// File: rtl/fma_token_pipe.sv
// 1-bit delay line tracking products in flight through the multiplier.
// Stage 0 is the LSB; the accumulator sees the MSB.
module fma_token_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic shift_i,
    input  logic din_i,
    output logic dout_o,
    output logic pending_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (flush_i) begin
            pipe_d = '0;
        end else if (shift_i) begin
            pipe_d = (pipe_q << 1) | DEPTH'(din_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout_o    = pipe_q[DEPTH-1];
    // Tokens still behind the output stage; the shift drops the output bit.
    assign pending_o = |(pipe_q << 1);

endmodule

// File: rtl/fma_acc_sequencer.sv
// Control FSM for one fused dot-product session: init-load, operand issue,
// product drain through the multiplier latency, and a held result handshake.
module fma_acc_sequencer
    import fma_acc_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = FMA_MUL_LATENCY,
    parameter int unsigned MAX_TERMS   = FMA_MAX_TERMS,
    parameter int unsigned CNT_W       = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CNT_W-1:0] cmd_len_i,
    input  logic             opnd_valid_i,
    output logic             opnd_ready_o,
    output logic             in_last_o,
    output logic             acc_load_o,
    output logic             acc_add_o,
    input  logic             abort_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] issued_o
);

    localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_TERMS);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, issued_q;
    logic             cmd_hs, opnd_hs, last_hs, abort_act;
    logic             pipe_shift, pipe_out, pipe_pending;

    assign cmd_hs    = cmd_valid_i && cmd_ready_o;
    assign opnd_hs   = opnd_valid_i && opnd_ready_o;
    assign last_hs   = opnd_hs && (issued_q == len_q - CNT_W'(1));
    assign abort_act = abort_i && (state_q inside {StLoad, StIssue, StDrain});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid_i) state_d = StLoad;
            StLoad:  state_d = (len_q == '0) ? StDone : StIssue;
            StIssue: if (last_hs) state_d = StDrain;
            // Leave once only the output stage can hold a token, so the last add lands.
            StDrain: if (!pipe_pending) state_d = StDone;
            StDone:  if (result_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_act) state_d = StIdle;
    end

    always_comb begin
        cmd_ready_o    = 1'b0;
        acc_load_o     = 1'b0;
        opnd_ready_o   = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = 1'b1;
        pipe_shift     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            StLoad:  acc_load_o = 1'b1;
            StIssue: begin
                opnd_ready_o = (issued_q < len_q);
                pipe_shift   = 1'b1;
            end
            StDrain: pipe_shift = 1'b1;
            StDone:  result_valid_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q    <= '0;
            issued_q <= '0;
        end else if (cmd_hs) begin
            len_q    <= (cmd_len_i > MaxLen) ? MaxLen : cmd_len_i;
            issued_q <= '0;
        end else if (abort_act) begin
            issued_q <= '0;
        end else if (opnd_hs) begin
            issued_q <= issued_q + CNT_W'(1);
        end
    end

    fma_token_pipe #(
        .DEPTH (MUL_LATENCY)
    ) u_token_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (abort_act),
        .shift_i   (pipe_shift),
        .din_i     (opnd_hs),
        .dout_o    (pipe_out),
        .pending_o (pipe_pending)
    );

    assign acc_add_o = pipe_out;
    assign in_last_o = last_hs;
    assign issued_o  = issued_q;

endmodule

// File: tb/tb_fma_acc_sequencer.sv
// Scoreboard bench: the driver predicts event cycles from the session rules,
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_fma_acc_sequencer;

    localparam int ML        = 2;
    localparam int MAX_TERMS = 256;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_len = '0;
    logic             opnd_valid = 1'b0;
    logic             opnd_ready;
    logic             in_last;
    logic             acc_load;
    logic             acc_add;
    logic             abort = 1'b0;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] issued;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int load_q[$], hs_q[$], last_q[$], add_q[$], rise_q[$], iss_q[$];
    logic prev_rv = 1'b0;
    logic prev_rr = 1'b0;

    fma_acc_sequencer #(
        .MUL_LATENCY (ML),
        .MAX_TERMS   (MAX_TERMS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_len_i      (cmd_len),
        .opnd_valid_i   (opnd_valid),
        .opnd_ready_o   (opnd_ready),
        .in_last_o      (in_last),
        .acc_load_o     (acc_load),
        .acc_add_o      (acc_add),
        .abort_i        (abort),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .busy_o         (busy),
        .issued_o       (issued)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_rv <= 1'b0;
            prev_rr <= 1'b0;
        end else begin
            if (acc_load)
                cmp_int("load_cycle", cyc, load_q.size() != 0 ? load_q.pop_front() : -1);
            if (opnd_valid && opnd_ready && !abort)
                cmp_int("opnd_hs_cycle", cyc, hs_q.size() != 0 ? hs_q.pop_front() : -1);
            if (in_last && !abort)
                cmp_int("in_last_cycle", cyc, last_q.size() != 0 ? last_q.pop_front() : -1);
            if (acc_add)
                cmp_int("acc_add_cycle", cyc, add_q.size() != 0 ? add_q.pop_front() : -1);
            if (result_valid && !prev_rv)
                cmp_int("result_rise_cycle", cyc, rise_q.size() != 0 ? rise_q.pop_front() : -1);
            if (result_valid && result_ready)
                cmp_int("result_issued", int'(issued), iss_q.size() != 0 ? iss_q.pop_front() : -1);
            if (prev_rv && !prev_rr)
                cmp_int("result_hold", int'(result_valid), 1);
            prev_rv <= result_valid;
            prev_rr <= result_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string nm);
        cmp_int({nm, "_cmd_ready"}, int'(cmd_ready), 1);
        cmp_int({nm, "_busy"}, int'(busy), 0);
        cmp_int({nm, "_acc_add"}, int'(acc_add), 0);
        cmp_int({nm, "_result_valid"}, int'(result_valid), 0);
        cmp_int({nm, "_opnd_ready"}, int'(opnd_ready), 0);
    endtask

    // Session model: operands are the first L valid cycles from cmd+2,
    // each product lands ML cycles later, result one cycle after the last add.
    task automatic run_session(input int len, input int gap_pct, input int gap_from,
                               input int gap_to, input int rdy_wait, input int abort_k,
                               input bit rst_drain);
        int t0, eff, n, c, rise, rdone, ta, idx;
        int h[$];
        bit vpat[$];
        bit v;
        t0  = cyc;
        eff = (len > MAX_TERMS) ? MAX_TERMS : len;
        c   = t0 + 2;
        n   = 0;
        while (n < eff) begin
            v = ($urandom_range(99) >= gap_pct);
            if (c - t0 >= gap_from && c - t0 <= gap_to) v = 1'b0;
            vpat.push_back(v);
            if (v) begin
                h.push_back(c);
                n++;
            end
            c++;
        end
        ta   = (abort_k > 0) ? h[abort_k-1] : -1;
        rise = (eff == 0) ? t0 + 2 : h[eff-1] + ML + 1;
        rdone = rise + rdy_wait;

        load_q.push_back(t0 + 1);
        if (abort_k > 0) begin
            for (int i = 0; i < abort_k - 1; i++) begin
                hs_q.push_back(h[i]);
                if (h[i] + ML <= ta) add_q.push_back(h[i] + ML);
            end
        end else if (!rst_drain) begin
            foreach (h[i]) begin
                hs_q.push_back(h[i]);
                add_q.push_back(h[i] + ML);
            end
            if (eff > 0) last_q.push_back(h[eff-1]);
            rise_q.push_back(rise);
            iss_q.push_back(eff);
        end else begin
            foreach (h[i]) begin
                hs_q.push_back(h[i]);
                if (h[i] + ML <= h[eff-1]) add_q.push_back(h[i] + ML);
            end
            last_q.push_back(h[eff-1]);
        end

        cmd_valid  = 1'b1;
        cmd_len    = CNT_W'(len);
        opnd_valid = 1'($urandom_range(1));
        step();
        cmd_valid = 1'b0;
        while (1) begin
            idx        = cyc - (t0 + 2);
            opnd_valid = (idx >= 0 && idx < vpat.size()) ? vpat[idx] : 1'($urandom_range(1));
            abort      = (cyc == ta);
            if (rst_drain && cyc == h[eff-1] + 1) begin
                #2;
                rst = 1'b1;
                #1;
                load_q.delete(); hs_q.delete(); last_q.delete();
                add_q.delete(); rise_q.delete(); iss_q.delete();
                chk_idle_outputs("async_rst");
                cmp_int("async_rst_issued", int'(issued), 0);
                cmp_int("async_rst_acc_load", int'(acc_load), 0);
                @(posedge clk);
                #1;
                rst        = 1'b0;
                opnd_valid = 1'b0;
                step();
                chk_idle_outputs("after_rst");
                break;
            end
            if (abort_k > 0) begin
                if (cyc == ta) begin
                    step();
                    abort      = 1'b0;
                    opnd_valid = 1'b0;
                    chk_idle_outputs("after_abort");
                    repeat (ML + 2) step();
                    break;
                end
            end else begin
                if (cyc >= rise) begin
                    cmd_valid = 1'b1;
                    cmd_len   = CNT_W'($urandom_range(12));
                    cmp_int("done_cmd_ready", int'(cmd_ready), 0);
                    cmp_int("done_busy", int'(busy), 1);
                end
                result_ready = (cyc >= rdone);
                if (cyc == rdone) begin
                    step();
                    result_ready = 1'b0;
                    cmd_valid    = 1'b0;
                    opnd_valid   = 1'b0;
                    cmp_int("post_done_cmd_ready", int'(cmd_ready), 1);
                    cmp_int("post_done_busy", int'(busy), 0);
                    break;
                end
            end
            step();
        end
        cmp_int("leftover_load", load_q.size(), 0);
        cmp_int("leftover_hs", hs_q.size(), 0);
        cmp_int("leftover_last", last_q.size(), 0);
        cmp_int("leftover_add", add_q.size(), 0);
        cmp_int("leftover_rise", rise_q.size(), 0);
        cmp_int("leftover_issued", iss_q.size(), 0);
    endtask

    initial begin
        #1;
        chk_idle_outputs("reset");
        cmp_int("reset_issued", int'(issued), 0);
        cmp_int("reset_in_last", int'(in_last), 0);
        cmp_int("reset_acc_load", int'(acc_load), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        run_session(3, 0, -1, -1, 0, 0, 1'b0);
        run_session(0, 0, -1, -1, 0, 0, 1'b0);
        run_session(4, 0, 3, 5, 1, 0, 1'b0);
        run_session(2, 0, -1, -1, 5, 0, 1'b0);
        run_session(5, 0, -1, -1, 0, 2, 1'b0);
        run_session(1, 0, -1, -1, 0, 0, 1'b0);
        run_session(3, 0, -1, -1, 0, 0, 1'b1);
        run_session(300, 10, -1, -1, 0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int l;
            int ak;
            l  = $urandom_range(12);
            ak = (l >= 2 && $urandom_range(3) == 0) ? $urandom_range(l - 1, 1) : 0;
            run_session(l, $urandom_range(50), -1, -1, $urandom_range(3), ak, 1'b0);
            if ($urandom_range(1) == 1) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
